cpu_uart_rx: RTL and testbench

UART receiver front end for the CPU's serial input. Synchronises the asynchronous `cpu_uart_rxd` pin into the CPU clock domain and decodes 8N1 frames using a bit-period timer. Received bytes are buffered in a small FIFO and handed to the CPU's load/store path over a valid/ready handshake. Sits between the board-level `cpu_uart_rxd` pin and the CPU core inside the CPU wrapper, and is clocked by the same (divided) CPU clock.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/cpu_uart_rx.sv | 128 ++++++++++++
 tb/tb_cpu_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: data width and the receiver FSM states.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous active-low reset.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_fire;
    logic             pop_fire;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);
    assign pop_data  = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_uart_rx.sv
// 8N1 UART receiver for the CPU serial input: pin synchroniser, bit-period timer,
// frame FSM and a receive FIFO drained over a valid/ready handshake.
module cpu_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT/2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);

    rx_state_t                 state;
    logic                      rxd_m;
    logic                      rxd_s;
    logic                      rxd_p;
    logic [TW-1:0]             timer;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;

    logic                      stop_sample;
    logic                      fifo_push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop_fire;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign stop_sample = (state == RX_STOP) && (timer == BIT_LAST);
    assign fifo_push   = stop_sample && rxd_s;
    assign pop_fire    = rready && !fifo_empty;
    assign rvalid      = (fifo_count != '0);

    // Data sampling happens mid-bit, so leaving STOP at its sample point lets a
    // start edge arriving at the nominal end of the stop bit be caught.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_m     <= 1'b1;
            rxd_s     <= 1'b1;
            rxd_p     <= 1'b1;
            state     <= RX_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rxd_m     <= rxd;
            rxd_s     <= rxd_m;
            rxd_p     <= rxd_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rxd_p && !rxd_s) begin
                        timer <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer == HALF_LAST) begin
                        if (rxd_s) begin
                            state <= RX_IDLE;
                        end else begin
                            timer   <= '0;
                            bit_idx <= '0;
                            state   <= RX_DATA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer == BIT_LAST) begin
                        shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
                        timer     <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        state <= RX_IDLE;
                        if (!rxd_s) begin
                            frame_err <= 1'b1;
                        end else if (fifo_full && !pop_fire) begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (shift_reg),
        .full      (fifo_full),
        .pop       (rready),
        .pop_data  (rdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_cpu_uart_rx.sv
// Self-checking bench for cpu_uart_rx: directed scenarios plus randomized frames,
// compared against a queue-based model of the receive buffer.
module tb_cpu_uart_rx;

    localparam int CPB          = 16;
    localparam int DEPTH        = 4;
    localparam int FRAME_CYCLES = 10 * CPB;
    // Cycles from the pin falling edge to the stop-bit sample: sync + edge detect,
    // half a bit to the start sample, then nine full bits.
    localparam int STOP_SAMPLE  = 2 + CPB/2 + 9*CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rready = 1'b0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int failures = 0;
    byte unsigned model_q[$];
    int exp_fe = 0;
    int exp_ov = 0;
    int seen_fe = 0;
    int seen_ov = 0;
    int wide_pulses = 0;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;

    cpu_uart_rx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) seen_fe++;
        if (overrun) seen_ov++;
        if ((frame_err && fe_prev) || (overrun && ov_prev)) wide_pulses++;
        fe_prev = frame_err;
        ov_prev = overrun;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame starting at the current negedge. pop_at pulses rready on
    // that frame cycle; abort_at applies a reset on that frame cycle instead.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok,
                                 input int pop_at, input int abort_at);
        bit ov_now = 1'b0;
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            if (c == abort_at) begin
                reset_n = 1'b0;
                rxd     = 1'b1;
                rready  = 1'b0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                model_q.delete();
                checkOutput("abort_flush", rvalid, 0);
                return;
            end
            if (c < CPB) rxd = 1'b0;
            else if (c < 9*CPB) rxd = data[(c-CPB)/CPB];
            else rxd = stop_ok;

            if (c == STOP_SAMPLE + 1) begin
                checkOutput("frame_err_pulse", frame_err, !stop_ok);
                checkOutput("overrun_pulse", overrun, ov_now);
                checkOutput("rvalid_post", rvalid, model_q.size() != 0);
                if (model_q.size() != 0) checkOutput("rdata_head", rdata, model_q[0]);
            end
            if (c == STOP_SAMPLE) begin
                checkOutput("rvalid_pre", rvalid, model_q.size() != 0);
            end

            rready = (c == pop_at);
            if (c == pop_at && model_q.size() != 0) begin
                checkOutput("pop_head", rdata, model_q[0]);
                void'(model_q.pop_front());
            end

            if (c == STOP_SAMPLE) begin
                if (!stop_ok) exp_fe++;
                else if (model_q.size() < DEPTH) model_q.push_back(data);
                else begin
                    exp_ov++;
                    ov_now = 1'b1;
                end
            end
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    task automatic drain_fifo(input string tag);
        while (model_q.size() != 0) begin
            checkOutput({tag, "_valid"}, rvalid, 1);
            checkOutput({tag, "_data"}, rdata, model_q[0]);
            void'(model_q.pop_front());
            rready = 1'b1;
            @(negedge clk);
        end
        rready = 1'b0;
        checkOutput({tag, "_empty"}, rvalid, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rvalid", rvalid, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_overrun", overrun, 0);
        reset_n = 1'b1;
        idle(4);

        // Single byte held until a single rready pulse
        applyStimulus(8'h55, 1'b1, -1, -1);
        idle(5);
        checkOutput("single_rvalid", rvalid, 1);
        checkOutput("single_rdata", rdata, 8'h55);
        drain_fifo("single");

        // rready while empty must be ignored
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checkOutput("empty_rready", rvalid, 0);

        // Short low glitch, then a real frame to prove the FSM recovered
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        checkOutput("glitch_rvalid", rvalid, 0);
        checkOutput("glitch_fe", seen_fe, exp_fe);
        applyStimulus(8'h5A, 1'b1, -1, -1);
        idle(3);
        drain_fifo("after_glitch");

        // Framing error followed by a clean byte
        applyStimulus(8'hA3, 1'b0, -1, -1);
        idle(3);
        checkOutput("ferr_empty", rvalid, 0);
        applyStimulus(8'h3C, 1'b1, -1, -1);
        idle(3);
        checkOutput("ferr_next_data", rdata, 8'h3C);
        drain_fifo("ferr");

        // Overrun on the fifth byte with nobody draining
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, -1, -1);
            idle(2);
        end
        checkOutput("overrun_total", seen_ov, 1);
        checkOutput("overrun_head", rdata, 8'h01);
        drain_fifo("overrun");

        // Full FIFO with a pop on the stop-sample cycle; back-to-back frames
        for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1'b1, -1, -1);
        idle(2);
        applyStimulus(8'h77, 1'b1, STOP_SAMPLE, -1);
        idle(2);
        checkOutput("fullpop_overrun", seen_ov, 1);
        checkOutput("fullpop_head", rdata, 8'h11);
        drain_fifo("fullpop");

        // Reset in the middle of data bit 3 flushes the FIFO
        applyStimulus(8'h42, 1'b1, -1, -1);
        idle(2);
        applyStimulus(8'hAA, 1'b1, -1, CPB + 3*CPB + CPB/2);
        idle(4);
        applyStimulus(8'hF0, 1'b1, -1, -1);
        idle(2);
        checkOutput("reset_mid_data", rdata, 8'hF0);
        drain_fifo("reset_mid");

        // Randomized frames, stop bits and pop points
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 6; i++) begin
                logic [7:0] data;
                bit         stop_ok;
                int         pop_at;
                data    = 8'($urandom);
                stop_ok = ($urandom_range(0, 9) != 0);
                case ($urandom_range(0, 2))
                    0:       pop_at = STOP_SAMPLE;
                    1:       pop_at = int'($urandom_range(0, FRAME_CYCLES - 1));
                    default: pop_at = -1;
                endcase
                applyStimulus(data, stop_ok, pop_at, -1);
                idle(stop_ok ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 6)));
            end
            drain_fifo("random");
        end

        idle(4);
        checkOutput("fe_total", seen_fe, exp_fe);
        checkOutput("ov_total", seen_ov, exp_ov);
        checkOutput("pulse_width", wide_pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
